// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK controller owning pc and IR, driving ALU and regfile controls.
module cpu_control_fsm #(
  parameter logic [31:0] PC_RESET = 32'd0,
  parameter logic [31:0] PC_STEP = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        instr_req,
  output logic [3:0]  aluSel,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic [3:0]  rd_addr,
  output logic [15:0] imm,
  output logic        b_imm_sel,
  output logic        reg_we,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t state;
  logic [31:0] ir;
  logic [3:0] op, nop;
  assign op = ir[31:28];
  assign nop = instr[31:28];
  assign rd_addr = ir[27:24];
  assign rs_addr = ir[23:20];
  assign rt_addr = ir[19:16];
  assign imm = ir[15:0];
  // Control outputs are loaded on the FETCH edge so they are valid throughout DECODE..WRITEBACK.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= PC_RESET;
      ir <= '0;
      instr_req <= 1'b1;
      aluSel <= 4'd0;
      b_imm_sel <= 1'b0;
      reg_we <= 1'b0;
      halted <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: if (instr_valid) begin
          state <= DECODE;
          ir <= instr;
          pc <= pc + PC_STEP;
          instr_req <= 1'b0;
          aluSel <= nop <= 4'd12 ? nop : 4'd0;
          b_imm_sel <= nop == 4'd8 || nop == 4'd9;
        end
        DECODE: begin
          state <= op == 4'd0 || op == 4'd13 ? FETCH : op >= 4'd14 ? HALT : EXECUTE;
          instr_req <= op == 4'd0 || op == 4'd13;
          halted <= op >= 4'd14;
          illegal <= op == 4'd14;
          if (op == 4'd13) pc <= {16'd0, ir[15:0]};
        end
        EXECUTE: if (op == 4'd10 || op == 4'd11) begin
          state <= FETCH;
          instr_req <= 1'b1;
          aluSel <= 4'd0;
          b_imm_sel <= 1'b0;
          if (zero) pc <= pc + {{16{ir[15]}}, ir[15:0]};
        end else begin
          state <= WRITEBACK;
          reg_we <= 1'b1;
        end
        WRITEBACK: begin
          state <= FETCH;
          instr_req <= 1'b1;
          reg_we <= 1'b0;
          aluSel <= 4'd0;
          b_imm_sel <= 1'b0;
        end
        HALT: state <= HALT;
        default: begin
          state <= FETCH;
          instr_req <= 1'b1;
          aluSel <= 4'd0;
          b_imm_sel <= 1'b0;
          reg_we <= 1'b0;
        end
      endcase
    end
  end
endmodule
